// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - op codes, divider FSM states and divider constants for ex_mdu
package ex_mdu_pkg;

   localparam int ALUOP_W = 8;

   localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
   localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
   localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
   localparam logic [ALUOP_W-1:0] EXE_MUL_OP   = 8'b1010_1001;

   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'd0,
      DIV_BYZERO = 2'd1,
      DIV_RUN    = 2'd2,
      DIV_END    = 2'd3
   } div_state_t;

   function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

endpackage

// File: rtl/ex_mdu_div_iter.sv
// rtl/ex_mdu_div_iter.sv - iterative restoring divider; result is {remainder, quotient}
// Operands must stay stable from start until the divider leaves IDLE.
module div_iter
   import ex_mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_signed,
   input  logic        annul,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        ready,
   output logic [63:0] result
);

   div_state_t  state;
   div_state_t  state_next;
   logic [5:0]  cnt;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] den;
   logic        quo_neg;
   logic        rem_neg;

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;
   logic [31:0] step_rem;
   logic [31:0] step_quo;
   logic [31:0] dividend_mag;
   logic [31:0] divisor_mag;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign dividend_mag = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
   assign divisor_mag  = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

   // quo starts as the dividend: its top bit shifts into rem while quotient bits enter at the bottom
   assign shifted  = {rem, quo[31]};
   assign diff     = shifted - {1'b0, den};
   assign fits     = shifted >= {1'b0, den};
   assign step_rem = 32'(fits ? diff : shifted);
   assign step_quo = {quo[30:0], fits};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DIV_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (annul) begin
         state_next = DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  state_next = (divisor == 32'd0) ? DIV_BYZERO : DIV_RUN;
               end
            end
            DIV_BYZERO: state_next = DIV_END;
            DIV_RUN: begin
               if (cnt == 6'(DIV_ITERS - 1)) begin
                  state_next = DIV_END;
               end
            end
            DIV_END: state_next = DIV_IDLE;
            default: state_next = DIV_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= 6'd0;
         quo     <= 32'd0;
         rem     <= 32'd0;
         den     <= 32'd0;
         quo_neg <= 1'b0;
         rem_neg <= 1'b0;
      end else if (!annul) begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  cnt <= 6'd0;
                  if (divisor == 32'd0) begin
                     // divide-by-zero reports the raw dividend, no sign correction
                     quo     <= 32'hFFFF_FFFF;
                     rem     <= dividend;
                     den     <= 32'd0;
                     quo_neg <= 1'b0;
                     rem_neg <= 1'b0;
                  end else begin
                     quo     <= dividend_mag;
                     rem     <= 32'd0;
                     den     <= divisor_mag;
                     quo_neg <= is_signed && (dividend[31] ^ divisor[31]);
                     rem_neg <= is_signed && dividend[31];
                  end
               end
            end
            DIV_RUN: begin
               cnt <= cnt + 6'd1;
               quo <= step_quo;
               rem <= step_rem;
            end
            default: begin
            end
         endcase
      end
   end

   assign quo_fix = quo_neg ? (~quo + 32'd1) : quo;
   assign rem_fix = rem_neg ? (~rem + 32'd1) : rem;

   assign busy   = (state == DIV_BYZERO) || (state == DIV_RUN);
   assign ready  = (state == DIV_END);
   assign result = {rem_fix, quo_fix};

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - EX-stage multiply/divide unit with architectural HI/LO registers
module ex_mdu
   import ex_mdu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [31:0]        reg1_i,
   input  logic [31:0]        reg2_i,
   input  logic               flush_i,
   output logic               stallreq_o,
   output logic [31:0]        result_o,
   output logic [31:0]        hi_o,
   output logic [31:0]        lo_o
);

   logic [31:0] hi;
   logic [31:0] lo;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_req;
   logic        div_busy;
   logic        div_ready;
   logic        div_idle;
   logic [63:0] div_result;

   assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
   assign prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

   assign div_req  = valid_i && is_div_op(aluop_i);
   assign div_idle = !div_busy && !div_ready;

   div_iter u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .start     (div_req),
      .is_signed (aluop_i == EXE_DIV_OP),
      .annul     (flush_i),
      .dividend  (reg1_i),
      .divisor   (reg2_i),
      .busy      (div_busy),
      .ready     (div_ready),
      .result    (div_result)
   );

   // END is deliberately not stalling: the held DIV leaves ID/EX as HI/LO are written
   assign stallreq_o = !rst && !flush_i && (div_busy || (div_idle && div_req));

   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (!flush_i) begin
         if (div_ready) begin
            hi <= div_result[63:32];
            lo <= div_result[31:0];
         end else if (valid_i) begin
            case (aluop_i)
               EXE_MULT_OP: begin
                  hi <= prod_s[63:32];
                  lo <= prod_s[31:0];
               end
               EXE_MULTU_OP: begin
                  hi <= prod_u[63:32];
                  lo <= prod_u[31:0];
               end
               EXE_MTHI_OP: hi <= reg1_i;
               EXE_MTLO_OP: lo <= reg1_i;
               default: begin
               end
            endcase
         end
      end
   end

   always_comb begin
      result_o = 32'd0;
      if (!rst && valid_i) begin
         case (aluop_i)
            EXE_MFHI_OP: result_o = hi;
            EXE_MFLO_OP: result_o = lo;
            EXE_MUL_OP:  result_o = prod_s[31:0];
            default:     result_o = 32'd0;
         endcase
      end
   end

   assign hi_o = hi;
   assign lo_o = lo;

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have reset rst, synchronous, active-high.
REQ-002 SHALL declare ports clk (in, 1) and rst (in, 1): clock and reset.
REQ-003 SHALL declare port valid_i (in, 1): ID/EX register holds a live instruction.
REQ-004 SHALL declare port aluop_i (in, AluOpBus 8): operation code from decode.
REQ-005 SHALL declare ports reg1_i and reg2_i (in, 32 each): operand 1 (dividend/multiplicand/MTxx source) and operand 2.
REQ-006 SHALL declare port flush_i (in, 1): annul the current instruction.
REQ-007 SHALL declare port stallreq_o (out, 1): request a pipeline stall; ID/EX holds aluop_i/reg1_i/reg2_i stable while it is high.
REQ-008 SHALL declare port result_o (out, 32): MFHI/MFLO/MUL result for the EX writeback mux.
REQ-009 SHALL declare ports hi_o and lo_o (out, 32 each): architectural HI and LO registers.

Function
REQ-010 SHALL decode ops MULT, MULTU, MUL, MFHI, MFLO, MTHI, MTLO, DIV, DIVU; every other aluop_i SHALL produce no state change and result_o=0.
REQ-011 SHALL, when MULT/MULTU is valid, write the signed/unsigned 64-bit product at the next edge: HI<=[63:32], LO<=[31:0]; no stall.
REQ-012 SHALL drive result_o combinationally: MFHI->HI, MFLO->LO, MUL->low 32 bits of the signed product; MUL SHALL NOT touch HI/LO.
REQ-013 SHALL, when MTHI/MTLO is valid, load reg1_i into HI/LO at the next edge, leaving the other register unchanged.
REQ-014 SHALL run division with FSM states IDLE, BYZERO, RUN, END.
REQ-015 IDLE->BYZERO SHALL occur when DIV/DIVU is valid and reg2_i==0; IDLE->RUN when DIV/DIVU is valid and reg2_i!=0, latching operand magnitudes (absolute values for DIV) and clearing a 6-bit counter.
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle, for 32 cycles (counter 0..31), then go to END.
REQ-017 BYZERO SHALL last one cycle and then go to END, with quotient 0xFFFFFFFF and remainder = reg1_i.
REQ-018 END SHALL last one cycle: LO<=quotient and HI<=remainder at its closing edge, then return to IDLE.
REQ-019 For DIV, the quotient SHALL be negated when operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-020 stallreq_o SHALL be combinational: high in BYZERO and RUN, high in IDLE when a valid DIV/DIVU is present and flush_i=0, and low in END.
REQ-021 Timing: accept cycle T0, then 32 RUN cycles, then END at T33; HI/LO are visible at T34.
REQ-022 The divide-by-zero path SHALL take T0, BYZERO, END: 3 cycles.
REQ-023 flush_i=1 in any state SHALL force IDLE at the next edge, suppress any HI/LO write that cycle, and drop stallreq_o in that same cycle.
REQ-024 A new DIV SHALL NOT be accepted while the FSM is outside IDLE.
REQ-025 Division SHALL restart only from IDLE, so a held instruction is never re-executed after END.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set HI=0, LO=0, state=IDLE and counter=0, and discard any division in progress.
REQ-027 SHALL hold stallreq_o=0 and result_o=0 combinationally while rst=1.

Structure
REQ-028 SHALL take all op codes from the shared defines header, with EXE_DIV_OP and EXE_DIVU_OP added alongside the existing MULT/MFHI codes.
REQ-029 SHALL keep FSM state encodings and the divider iteration count (32) as constants in the same header.
REQ-030 SHALL place the iterative divider in one sub-module, div_iter (start, signed, annul, ready, 64-bit {rem,quo}), with HI/LO, the multiplier and the op decode in ex_mdu.

Verification
REQ-031 MULT, reg1=0xFFFFFFFE (-2), reg2=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA next cycle, stallreq_o never high.
REQ-032 DIVU, reg1=100, reg2=7 -> stallreq_o high for exactly 33 cycles, then LO=14, HI=2 one cycle after END.
REQ-033 DIV, reg1=-7 (0xFFFFFFF9), reg2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIV, reg2=0, reg1=5 -> 3-cycle sequence, LO=0xFFFFFFFF, HI=5.
REQ-035 flush_i pulsed at RUN cycle 10 of a DIVU -> stallreq_o low that cycle, HI/LO unchanged, next DIVU completes correctly.
REQ-036 MTHI 0x12345678, then MFHI -> result_o=0x12345678; rst asserted mid-division -> HI=LO=0, IDLE, stallreq_o=0.
